// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - run/pause/step sequencer with generation counter and pattern detection
module life_sequencer #(
    parameter int unsigned TICK_DIV  = 12_000_000,
    parameter int unsigned GEN_W     = 16,
    parameter bit          AUTO_HALT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_toggle,
    input  logic             step,
    input  logic [1:0]       speed,
    input  logic [63:0]      grid_in,
    output logic             tick,
    output logic             running,
    output logic             halted,
    output logic [GEN_W-1:0] gen_count,
    output logic             extinct,
    output logic             still,
    output logic             osc2
);
    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [31:0] DIV   = 32'(TICK_DIV);

    typedef enum logic [1:0] {S_PAUSE, S_RUN, S_CHECK, S_HALT} state_t;

    state_t             state, state_nx;
    logic               origin_run, origin_run_nx;
    logic [CNT_W-1:0]   presc, presc_nx;
    logic [63:0]        prev, prev2, prev_nx, prev2_nx;
    logic               pv, pv2, pv_nx, pv2_nx;
    logic               tick_nx, capture;
    logic [GEN_W-1:0]   gen_nx;
    logic               ext_nx, still_nx, osc2_nx;
    logic [31:0]        limit;
    logic               term;

    assign limit   = DIV >> {speed, 1'b0};
    assign term    = 32'(presc) >= (limit - 32'd1);
    assign running = (state == S_RUN) || (state == S_CHECK && origin_run);
    assign halted  = (state == S_HALT);

    always_comb begin
        state_nx      = state;
        origin_run_nx = origin_run;
        presc_nx      = presc;
        tick_nx       = 1'b0;
        capture       = 1'b0;
        prev_nx       = prev;
        prev2_nx      = prev2;
        pv_nx         = pv;
        pv2_nx        = pv2;
        gen_nx        = gen_count;
        ext_nx        = extinct;
        still_nx      = still;
        osc2_nx       = osc2;
        if (tick) begin
            // grid advances at the end of this cycle, so the check waits one cycle
            state_nx = S_CHECK;
            if (state == S_RUN)
                presc_nx = presc + 1'b1;
        end else begin
            case (state)
                S_PAUSE, S_HALT: begin
                    if (run_toggle) begin
                        state_nx = S_RUN;
                        presc_nx = '0;
                        capture  = 1'b1;
                    end else if (step) begin
                        state_nx      = S_PAUSE;
                        origin_run_nx = 1'b0;
                        tick_nx       = 1'b1;
                        capture       = 1'b1;
                    end
                end
                S_RUN: begin
                    if (run_toggle) begin
                        state_nx = S_PAUSE;
                    end else if (term) begin
                        tick_nx       = 1'b1;
                        presc_nx      = '0;
                        origin_run_nx = 1'b1;
                    end else begin
                        presc_nx = presc + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (gen_count != '1)
                        gen_nx = gen_count + 1'b1;
                    ext_nx   = extinct | (grid_in == '0);
                    still_nx = still | (pv && grid_in == prev);
                    osc2_nx  = osc2 | (pv2 && grid_in == prev2 && grid_in != prev);
                    prev2_nx = prev;
                    pv2_nx   = pv;
                    prev_nx  = grid_in;
                    pv_nx    = 1'b1;
                    if (AUTO_HALT && (ext_nx || still_nx || osc2_nx))
                        state_nx = S_HALT;
                    else
                        state_nx = origin_run ? S_RUN : S_PAUSE;
                end
                default: state_nx = S_PAUSE;
            endcase
        end
        if (capture) begin
            prev_nx = grid_in;
            pv_nx   = 1'b1;
            pv2_nx  = 1'b0;
            if (state == S_HALT) begin
                ext_nx   = 1'b0;
                still_nx = 1'b0;
                osc2_nx  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_PAUSE;
            origin_run <= 1'b0;
            presc      <= '0;
            tick       <= 1'b0;
            prev       <= '0;
            prev2      <= '0;
            pv         <= 1'b0;
            pv2        <= 1'b0;
            gen_count  <= '0;
            extinct    <= 1'b0;
            still      <= 1'b0;
            osc2       <= 1'b0;
        end else begin
            state      <= state_nx;
            origin_run <= origin_run_nx;
            presc      <= presc_nx;
            tick       <= tick_nx;
            prev       <= prev_nx;
            prev2      <= prev2_nx;
            pv         <= pv_nx;
            pv2        <= pv2_nx;
            gen_count  <= gen_nx;
            extinct    <= ext_nx;
            still      <= still_nx;
            osc2       <= osc2_nx;
        end
    end
endmodule
